mul_writeback: RTL and testbench
================================

MUL_WRITEBACK -- requirements
Module: mul_writeback

Interface
REQ-001 The block SHALL have clock clk and reset rst (asynchronous, active-high).
REQ-002 Ports, in order, SHALL be:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a multiply; sampled at posedge clk in IDLE only
- op_a  in  8  multiplicand (register-file ReadData1)
- op_b  in  8  multiplier (register-file ReadData2)
- dest  in  3  destination register index for the low byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- wb_en  out  1  register-file write enable (RegWriteEn)
- wb_reg  out  3  register-file write index (WriteReg)
- wb_data  out  8  register-file write data (WriteData)
- product  out  16  last completed unsigned product
REQ-003 Parameters SHALL be none; widths SHALL come from the shared package.

Function
REQ-010 Operation SHALL be an unsigned 8x8 -> 16-bit iterative shift-add multiply.
REQ-011 The FSM SHALL have states IDLE, MUL, WB_LO, WB_HI and DONE.
REQ-012 In IDLE with start=1 at a posedge, the block SHALL latch op_a, op_b and dest, clear the accumulator and the 3-bit iteration counter, and enter MUL.
REQ-013 In MUL, each posedge SHALL add the multiplicand to the upper accumulator half when multiplier bit 0 = 1, then shift {carry, acc, multiplier} right by 1.
REQ-014 After exactly 8 MUL cycles, with the counter wrapping 7 -> 0, the FSM SHALL enter WB_LO.
- This latency SHALL be fixed and SHALL NOT terminate early, including for zero operands.
REQ-015 On WB_LO entry, product SHALL update to the full 16-bit result.
REQ-016 In WB_LO, outputs SHALL be wb_en=1, wb_reg=dest, wb_data=product[7:0] for exactly one cycle; the next state SHALL be WB_HI.
REQ-017 In WB_HI, outputs SHALL be wb_en=1, wb_reg=(dest+1) mod 8, wb_data=product[15:8] for exactly one cycle.
- dest=7 SHALL wrap to index 0; the write SHALL still be issued (the register file discards R0 writes).
REQ-018 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-019 If start is asserted at edge N, the following timing SHALL hold: WB_LO in cycle N+8..N+9, WB_HI in N+9..N+10, DONE in N+10..N+11, and busy=1 from N through N+11.
REQ-020 start SHALL be ignored in all non-IDLE states.
- With start held high, the next operation SHALL be accepted at the first IDLE edge after DONE.
REQ-021 Outside WB_LO and WB_HI, wb_en, wb_reg and wb_data SHALL be 0.
REQ-022 All outputs SHALL be driven from registers or decoded from the state register only, with no combinational path from the inputs.
REQ-023 op_a and op_b changes after the start edge SHALL NOT affect the result.

Reset
REQ-030 rst SHALL force IDLE immediately, asynchronously and at any point including mid-MUL or mid-writeback.
- busy, done, wb_en, wb_reg, wb_data and product SHALL reset to 0.
- Accumulator, counter and latched operands SHALL reset to 0.
REQ-031 A write-back interrupted by reset SHALL NOT be reissued after rst deasserts.
REQ-032 The first start SHALL be accepted at the first posedge after rst deasserts.

Structure
REQ-040 The shared package SHALL hold:
- the FSM state enum typedef;
- DATA_W=8, REG_ADDR_W=3, PROD_W=16, MUL_ITER=8.
REQ-041 The datapath (accumulator, multiplier shift register, iteration counter) SHALL be a sub-module named mul_dp.
- The FSM and write-back output decode SHALL stay in mul_writeback.

Verification
REQ-050 start, op_a=13, op_b=11, dest=2 -> WB_LO writes 0x8F to R2, WB_HI writes 0x00 to R3, done at N+10, product=0x008F.
REQ-051 op_a=255, op_b=255, dest=7 -> wb_data 0x01 to R7 then 0xFE to R0 (wrap), product=0xFE01.
REQ-052 op_a=0, op_b=200 -> busy for exactly 11 cycles, writes 0x00 and 0x00, done pulse exactly one cycle.
REQ-053 start held high for 30 cycles with changing operands -> exactly two operations complete back-to-back, each using operands sampled at its own start edge.
REQ-054 rst pulsed in cycle N+5 of a multiply -> all outputs 0 immediately, no wb_en pulse follows, product remains 0.
REQ-055 Connected to RegisterFile: multiply 9x7 into dest=4, then read R4/R5 -> 63 and 0.

Source files
------------

// File: rtl/mul_writeback_pkg.sv
// Shared widths, FSM state encoding and small helpers for the multiply/write-back block.
package mul_writeback_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int PROD_W     = 16;
  localparam int MUL_ITER   = 8;
  localparam int CNT_W      = $clog2(MUL_ITER);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    WB_LO = 3'd2,
    WB_HI = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Register index of the high byte; wraps 7 -> 0 (R0 writes are dropped by the register file).
  function automatic logic [REG_ADDR_W-1:0] hi_reg(input logic [REG_ADDR_W-1:0] r);
    return r + REG_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mul_dp.sv
// Shift-add multiply datapath: multiplicand, accumulator (upper half),
// multiplier shift register (lower half) and iteration counter.
module mul_dp
  import mul_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              last_o,
  output logic [PROD_W-1:0] prod_next_o
);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   sum;

  // One iteration: conditional add into the upper half, then shift {carry, acc, mplr} right.
  always_comb begin
    sum         = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_d       = sum[DATA_W:1];
    mplr_d      = {sum[0], mplr_q[DATA_W-1:1]};
    prod_next_o = {acc_d, mplr_d};
    last_o      = (cnt_q == CNT_W'(MUL_ITER - 1));
  end

  // Operand latch on load, one iteration per step; counter wraps naturally after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      mcand_q <= op_a_i;
      acc_q   <= '0;
      mplr_q  <= op_b_i;
      cnt_q   <= '0;
    end else if (step_i) begin
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_writeback.sv
// Iterative 8x8 unsigned multiplier that writes its 16-bit result back to the
// register file as two byte writes (low byte to dest, high byte to dest+1).
// Control: start is sampled only in IDLE. Every output is decoded from the
// state register or comes straight from a register.
module mul_writeback
  import mul_writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  busy,
  output logic                  done,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic [PROD_W-1:0]     product
);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [PROD_W-1:0]     product_q;
  logic                  accept;
  logic                  dp_last;
  logic [PROD_W-1:0]     dp_prod_next;

  assign accept = (state_q == IDLE) && start;

  mul_dp u_dp (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .step_i      (state_q == MUL),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .last_o      (dp_last),
    .prod_next_o (dp_prod_next)
  );

  // State register; reset aborts any operation, including a pending write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed 8-cycle MUL phase, then two write-back cycles and a done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (dp_last) state_d = WB_LO;
      WB_LO:   state_d = WB_HI;
      WB_HI:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Destination latch at accept and product capture on the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q    <= '0;
      product_q <= '0;
    end else begin
      if (accept) dest_q <= dest;
      if (state_q == MUL && dp_last) product_q <= dp_prod_next;
    end
  end

  // Output decode from the state register and result/destination registers.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    wb_en   = 1'b0;
    wb_reg  = '0;
    wb_data = '0;
    case (state_q)
      WB_LO: begin
        wb_en   = 1'b1;
        wb_reg  = dest_q;
        wb_data = product_q[DATA_W-1:0];
      end
      WB_HI: begin
        wb_en   = 1'b1;
        wb_reg  = hi_reg(dest_q);
        wb_data = product_q[PROD_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_mul_writeback.sv
// Testbench for mul_writeback: directed and random multiplies, back-to-back
// starts, wrap of the high-byte index, mid-operation reset, and a simple
// register-file model fed by the write-back port.
module tb_mul_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  op_a, op_b;
  logic [2:0]  dest;
  logic        busy, done, wb_en;
  logic [2:0]  wb_reg;
  logic [7:0]  wb_data;
  logic [15:0] product;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int wb_cnt  = 0;

  // Expected register writes in order: {reg, data}.
  logic [10:0] exp_q[$];
  logic [7:0]  rf [8];

  mul_writeback dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .dest    (dest),
    .busy    (busy),
    .done    (done),
    .wb_en   (wb_en),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .product (product)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the next expected write; idle write port must be zero.
  always @(negedge clk) begin
    logic [10:0] e;
    if (wb_en === 1'b1) begin
      wb_cnt++;
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $error("FAIL wb_unexpected: observed write R%0d=0x%0h, expected no write", wb_reg, wb_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_write", {21'b0, wb_reg, wb_data}, {21'b0, e});
      end
    end else begin
      check("wb_idle_zero", {21'b0, wb_reg, wb_data}, 32'h0);
    end
  end

  // Register-file model: R0 discards writes.
  always @(posedge clk) begin
    if (rst !== 1'b1 && wb_en === 1'b1 && wb_reg != 3'd0) rf[wb_reg] <= wb_data;
  end

  // Driver: issue one multiply from a negedge and check the cycle-by-cycle protocol.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
    logic [15:0] p;
    p = {8'b0, a} * {8'b0, b};
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    dest  = d;
    exp_q.push_back({d, p[7:0]});
    exp_q.push_back({d + 3'd1, p[15:8]});
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 8'($urandom);
    op_b  = 8'($urandom);
    dest  = 3'($urandom);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("busy",  {31'b0, busy},  {31'b0, (k <= 10)});
      check("done",  {31'b0, done},  {31'b0, (k == 10)});
      check("wb_en", {31'b0, wb_en}, {31'b0, (k == 8 || k == 9)});
      if (k >= 8) check("product", {16'b0, product}, {16'b0, p});
    end
  endtask

  initial begin
    logic [7:0]  ra [30];
    logic [7:0]  rb [30];
    logic [2:0]  rd [30];
    logic [15:0] p;
    int          dn;
    int          wb0;

    foreach (rf[i]) rf[i] = 8'h00;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    dest  = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",    {31'b0, busy},    32'h0);
    check("rst_done",    {31'b0, done},    32'h0);
    check("rst_wb_en",   {31'b0, wb_en},   32'h0);
    check("rst_product", {16'b0, product}, 32'h0);

    // First start right after reset release; 13 x 11 into R2/R3
    rst = 1'b0;
    run_op(8'd13, 8'd11, 3'd2);
    check("req050_product", {16'b0, product}, 32'h008F);

    // 255 x 255 into R7, high byte wraps to R0
    run_op(8'd255, 8'd255, 3'd7);
    check("req051_product", {16'b0, product}, 32'hFE01);

    // Zero multiplicand: full latency, zero writes
    run_op(8'd0, 8'd200, 3'($urandom_range(0, 7)));
    check("req052_product", {16'b0, product}, 32'h0000);

    // Register file readback
    run_op(8'd9, 8'd7, 3'd4);
    check("rf_r4", {24'b0, rf[4]}, 32'd63);
    check("rf_r5", {24'b0, rf[5]}, 32'd0);

    // Random operands
    for (int i = 0; i < 6; i++)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));

    // start held high 30 cycles with operands changing every cycle
    for (int j = 0; j < 30; j++) begin
      ra[j] = 8'($urandom_range(0, 255));
      rb[j] = 8'($urandom_range(0, 255));
      rd[j] = 3'($urandom_range(0, 7));
    end
    dn = 0;
    for (int j = 0; j < 30; j++) begin
      start = 1'b1;
      op_a  = ra[j];
      op_b  = rb[j];
      dest  = rd[j];
      if (j % 12 == 0) begin
        p = {8'b0, ra[j]} * {8'b0, rb[j]};
        exp_q.push_back({rd[j], p[7:0]});
        exp_q.push_back({rd[j] + 3'd1, p[15:8]});
      end
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) dn++;
      check("b2b_done", {31'b0, done}, {31'b0, (j == 10 || j == 22)});
    end
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("b2b_done_count", dn, 32'd2);
    p = {8'b0, ra[24]} * {8'b0, rb[24]};
    check("b2b_last_product", {16'b0, product}, {16'b0, p});
    check("b2b_idle", {31'b0, busy}, 32'h0);

    // Reset in cycle N+5 of a multiply: outputs clear at once, no write-back follows
    start = 1'b1;
    op_a  = 8'($urandom_range(1, 255));
    op_b  = 8'($urandom_range(1, 255));
    dest  = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",    {31'b0, busy},    32'h0);
    check("mid_rst_done",    {31'b0, done},    32'h0);
    check("mid_rst_wb_en",   {31'b0, wb_en},   32'h0);
    check("mid_rst_wb_reg",  {29'b0, wb_reg},  32'h0);
    check("mid_rst_wb_data", {24'b0, wb_data}, 32'h0);
    check("mid_rst_product", {16'b0, product}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wb0 = wb_cnt;
    repeat (16) @(negedge clk);
    check("mid_rst_no_wb",    wb_cnt - wb0, 32'd0);
    check("mid_rst_product2", {16'b0, product}, 32'h0);
    check("mid_rst_idle",     {31'b0, busy}, 32'h0);

    // Recovery: start accepted at the first edge after another reset release
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
